// File: rtl/spike_gen.sv
// spike_gen: programmable pulse-train source for exercising a spike detector.
// A train is a sequence of PULSE/GAP pairs; every parameter is captured on
// start so the inputs may move freely while a train is running.
// Optional build macro: SPIKE_GEN_NOISE_EN replaces the constant zero baseline
// with small pseudo-random noise from a 16-bit LFSR (pulse samples stay exact).
module spike_gen (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic signed [11:0] amp,
  input  logic        [2:0]  width,
  input  logic        [7:0]  period,
  input  logic        [7:0]  count,
  output logic signed [11:0] q,
  output logic               tag,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic        [1:0]  state_reg,  state_next;
  logic        [7:0]  ph_reg,     ph_next;     // 1-based cycle index inside current phase
  logic        [7:0]  pcnt_reg,   pcnt_next;   // completed pulses in this train
  logic signed [11:0] amp_reg,    amp_next;
  logic        [2:0]  width_reg,  width_next;
  logic        [7:0]  period_reg, period_next;
  logic        [7:0]  count_reg,  count_next;
  logic signed [11:0] q_reg,      q_next;
  logic               tag_reg,    tag_next;
  logic               busy_reg,   busy_next;
  logic               done_reg,   done_next;

  logic        [7:0]  w_eff;
  logic        [7:0]  p_eff;
  logic        [7:0]  p_eff_next;
  logic signed [11:0] baseline;

`ifdef SPIKE_GEN_NOISE_EN
  logic [15:0] lfsr_reg;
  logic        lfsr_fb;

  assign lfsr_fb  = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  // Low three LFSR bits, sign-extended, give a baseline in -4..+3.
  assign baseline = {{9{lfsr_reg[2]}}, lfsr_reg[2:0]};

  // Free-running Fibonacci LFSR, reseeded so every run after reset repeats.
  always_ff @(posedge clk) begin
    if (rst) lfsr_reg <= 16'hACE1;
    else     lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
  end
`else
  assign baseline = '0;
`endif

  // A width or period of zero behaves as one sample.
  assign w_eff      = (width_reg  == 3'd0) ? 8'd1 : {5'd0, width_reg};
  assign p_eff      = (period_reg == 8'd0) ? 8'd1 : period_reg;
  assign p_eff_next = (period_next == 8'd0) ? 8'd1 : period_next;

  // Next-state logic; the registered outputs are derived from the next state
  // so that q/busy/tag/done line up with the state they describe.
  always_comb begin
    state_next  = state_reg;
    ph_next     = ph_reg;
    pcnt_next   = pcnt_reg;
    amp_next    = amp_reg;
    width_next  = width_reg;
    period_next = period_reg;
    count_next  = count_reg;
    q_next      = baseline;
    tag_next    = 1'b0;
    busy_next   = 1'b0;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          amp_next    = amp;
          width_next  = width;
          period_next = period;
          count_next  = count;
          pcnt_next   = 8'd0;
          state_next  = PULSE;
          ph_next     = 8'd1;
        end
      end
      PULSE: begin
        if (stop) begin
          state_next = IDLE;
          ph_next    = 8'd0;
        end else if (ph_reg >= w_eff) begin
          state_next = GAP;
          ph_next    = 8'd1;
        end else begin
          ph_next = ph_reg + 8'd1;
        end
      end
      GAP: begin
        if (stop) begin
          state_next = IDLE;
          ph_next    = 8'd0;
        end else if (ph_reg >= p_eff) begin
          // Counter is allowed to wrap in continuous mode; only count!=0 compares.
          pcnt_next = pcnt_reg + 8'd1;
          if ((count_reg != 8'd0) && (pcnt_next == count_reg)) begin
            state_next = IDLE;
            ph_next    = 8'd0;
          end else begin
            state_next = PULSE;
            ph_next    = 8'd1;
          end
        end else begin
          ph_next = ph_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        ph_next    = 8'd0;
      end
    endcase

    busy_next = (state_next != IDLE);

    if (stop && (state_reg != IDLE)) begin
      q_next = '0;
    end else if (state_next == PULSE) begin
      q_next = amp_next;
    end

    tag_next = (state_next == PULSE) && (ph_next == 8'd1) && (width_next >= 3'd3);

    // done accompanies the last GAP sample of the final pulse, so it is raised
    // one edge ahead of the GAP->IDLE transition.
    done_next = (state_next == GAP) && (ph_next == p_eff_next) &&
                (count_next != 8'd0) && ((pcnt_next + 8'd1) == count_next);
  end

  // State, parameter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      ph_reg     <= 8'd0;
      pcnt_reg   <= 8'd0;
      amp_reg    <= '0;
      width_reg  <= 3'd0;
      period_reg <= 8'd0;
      count_reg  <= 8'd0;
      q_reg      <= '0;
      tag_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ph_reg     <= ph_next;
      pcnt_reg   <= pcnt_next;
      amp_reg    <= amp_next;
      width_reg  <= width_next;
      period_reg <= period_next;
      count_reg  <= count_next;
      q_reg      <= q_next;
      tag_reg    <= tag_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign q    = q_reg;
  assign tag  = tag_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_spike_gen.sv
// Self-checking bench for spike_gen: table of directed trains, hand-written
// reset/abort sequences and randomized trains checked against a sample-list
// model built directly from the pulse-train rules.
module tb_spike_gen;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic signed [11:0] amp;
  logic        [2:0]  width;
  logic        [7:0]  period;
  logic        [7:0]  count;
  logic signed [11:0] q;
  logic               tag;
  logic               busy;
  logic               done;

  spike_gen dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .amp   (amp),
    .width (width),
    .period(period),
    .count (count),
    .q     (q),
    .tag   (tag),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // One expected output sample; base=1 means "baseline value" (0, or noise).
  typedef struct {
    bit                 base;
    logic signed [11:0] val;
    bit                 tag;
    bit                 busy;
    bit                 done;
  } samp_t;

  typedef struct {
    string name;
    int    a, w, p, c, stop_at;
    int    exp_busy, exp_tag, exp_done;
  } vec_t;

  samp_t              exp_q[$];
  logic signed [11:0] cap_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic chk_q(input string name, input int got, input bit base, input int want);
    if (base) begin
`ifdef SPIKE_GEN_NOISE_EN
      total++;
      if (got < -4 || got > 3) begin
        bad++;
        $display("FAIL %s: got %0d expected baseline in -4..3", name, got);
      end
`else
      chk(name, got, 0);
`endif
    end else begin
      chk(name, got, want);
    end
  endtask

  // Expected sample list: count pulses of max(w,1) amp samples followed by
  // max(p,1) baseline samples; done on the final gap sample; optional stop.
  task automatic build_model(input logic signed [11:0] a, input int w, input int p,
                             input int c, input int stop_at);
    int we, pe, k;
    samp_t s;
    exp_q.delete();
    we = (w == 0) ? 1 : w;
    pe = (p == 0) ? 1 : p;
    k  = 0;
    while ((c == 0) ? (exp_q.size() < stop_at) : (k < c)) begin
      for (int i = 0; i < we; i++) begin
        s = '{base: 1'b0, val: a, tag: (i == 0 && w >= 3), busy: 1'b1, done: 1'b0};
        exp_q.push_back(s);
      end
      for (int j = 0; j < pe; j++) begin
        s = '{base: 1'b1, val: 12'sd0, tag: 1'b0, busy: 1'b1,
              done: (c != 0 && k == c - 1 && j == pe - 1)};
        exp_q.push_back(s);
      end
      k++;
    end
    if (stop_at > 0 && stop_at <= exp_q.size()) begin
      while (exp_q.size() > stop_at) void'(exp_q.pop_back());
      s = '{base: 1'b0, val: 12'sd0, tag: 1'b0, busy: 1'b0, done: 1'b0};
    end else begin
      s = '{base: 1'b1, val: 12'sd0, tag: 1'b0, busy: 1'b0, done: 1'b0};
    end
    exp_q.push_back(s);
  endtask

  task automatic run_train(input string label, input logic signed [11:0] a, input int w,
                           input int p, input int c, input int stop_at,
                           output int nbusy, output int ntag, output int ndone);
    samp_t e;
    int n;
    nbusy = 0; ntag = 0; ndone = 0;
    build_model(a, w, p, c, stop_at);
    n = exp_q.size();
    amp = a; width = 3'(w); period = 8'(p); count = 8'(c);
    start = 1'b1; stop = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      e = exp_q[i];
      cap_q.push_back(q);
      chk_q({label, " q"}, int'(q), e.base, int'(e.val));
      chk({label, " flags(tag,busy,done)"}, int'({tag, busy, done}),
          int'({e.tag, e.busy, e.done}));
      nbusy += int'(busy); ntag += int'(tag); ndone += int'(done);
      if (i == n - 1) break;
      stop = (stop_at > 0 && i + 1 == stop_at);
      // Scramble inputs while busy: start must be ignored and parameters held.
      start  = 1'($urandom);
      amp    = 12'($urandom);
      width  = 3'($urandom);
      period = 8'($urandom);
      count  = 8'($urandom);
      tick();
    end
    start = 1'b0; stop = 1'b0;
    $display("train %s amp=%0d w=%0d p=%0d c=%0d stop_at=%0d busy=%0d tags=%0d done=%0d",
             label, a, w, p, c, stop_at, nbusy, ntag, ndone);
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    tick();
    chk("reset q", int'(q), 0);
    chk("reset flags", int'({tag, busy, done}), 0);
    rst = 1'b0;
  endtask

  vec_t tbl[8];
  int nb, nt, nd;

  initial begin
    tbl[0] = '{"basic",    100, 3,   4, 2,   0,  14, 2, 1};
    tbl[1] = '{"w2",        50, 2,   2, 1,   0,   4, 0, 1};
    tbl[2] = '{"zeros",     77, 0,   0, 3,   0,   6, 0, 1};
    tbl[3] = '{"neg",     -200, 7,   1, 2,   0,  16, 2, 1};
    tbl[4] = '{"cont",       9, 4,   0, 0,  20,  20, 4, 0};
    tbl[5] = '{"longgap", -2048, 1, 255, 1,   0, 256, 0, 1};
    tbl[6] = '{"wrap",       5, 1,   1, 0, 600, 600, 0, 0};
    tbl[7] = '{"abort",    100, 3,   4, 2,   9,   9, 2, 0};

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    amp = '0; width = '0; period = '0; count = '0;
    tick();
    do_reset();

    for (int i = 0; i < 8; i++) begin
      run_train(tbl[i].name, 12'(tbl[i].a), tbl[i].w, tbl[i].p, tbl[i].c,
                tbl[i].stop_at, nb, nt, nd);
      chk({tbl[i].name, " busy cycles"}, nb, tbl[i].exp_busy);
      chk({tbl[i].name, " tag count"},   nt, tbl[i].exp_tag);
      chk({tbl[i].name, " done count"},  nd, tbl[i].exp_done);
      tick();
    end

    // start and stop together in IDLE: stay idle.
    amp = 12'sd123; width = 3'd3; period = 8'd2; count = 8'd1;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start+stop flags", int'({tag, busy, done}), 0);
    chk_q("start+stop q", int'(q), 1'b1, 0);
    $display("seq start+stop busy=%0d", busy);

    // Reset during the second PULSE cycle, then restart on the very next clock.
    amp = 12'sd33; width = 3'd4; period = 8'd3; count = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("midrst cycle1 q", int'(q), 33);
    tick();
    chk("midrst cycle2 busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    chk("midrst q", int'(q), 0);
    chk("midrst flags", int'({tag, busy, done}), 0);
    rst = 1'b0;
    amp = 12'sd44; width = 3'd3; period = 8'd2; count = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart q", int'(q), 44);
    chk("restart flags", int'({tag, busy, done}), 3'b110);
    repeat (4) tick();
    chk("restart done flags", int'({tag, busy, done}), 3'b011);
    tick();
    chk("restart idle flags", int'({tag, busy, done}), 0);
    $display("seq midreset restart busy=%0d", busy);

    // Randomized trains.
    for (int r = 0; r < 20; r++) begin
      int a, w, p, c, len, sa;
      a = int'($urandom_range(0, 4095)) - 2048;
      w = $urandom_range(0, 7);
      p = $urandom_range(0, 12);
      c = $urandom_range(0, 4);
      len = c * (((w == 0) ? 1 : w) + ((p == 0) ? 1 : p));
      if (c == 0)                  sa = $urandom_range(1, 60);
      else if ($urandom % 4 == 0)  sa = $urandom_range(1, len);
      else                         sa = 0;
      run_train($sformatf("rnd%0d", r), 12'(a), w, p, c, sa, nb, nt, nd);
      repeat ($urandom_range(0, 2)) tick();
    end

`ifdef SPIKE_GEN_NOISE_EN
    begin
      logic signed [11:0] first_q[$];
      do_reset();
      cap_q.delete();
      run_train("noise1", -12'sd200, 3, 5, 2, 0, nb, nt, nd);
      first_q = cap_q;
      do_reset();
      cap_q.delete();
      run_train("noise2", -12'sd200, 3, 5, 2, 0, nb, nt, nd);
      chk("noise repeat length", cap_q.size(), first_q.size());
      for (int i = 0; i < first_q.size() && i < cap_q.size(); i++)
        chk($sformatf("noise repeat q[%0d]", i), int'(cap_q[i]), int'(first_q[i]));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_gen.md
SPIKE_GEN -- requirements
Module: spike_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: begin a pulse train; sampled only in IDLE.
REQ-004 SHALL have port stop, input, 1 bit: abort the train.
REQ-005 SHALL have port amp, input, signed 12 bit: pulse sample value, latched at start.
REQ-006 SHALL have port width, input, 3 bit: samples per pulse, latched at start; 0 treated as 1.
REQ-007 SHALL have port period, input, 8 bit: baseline samples between pulses, latched at start; 0 treated as 1.
REQ-008 SHALL have port count, input, 8 bit: pulses per train, latched at start; 0 = continuous until stop.
REQ-009 SHALL have port q, output, signed 12 bit: registered sample stream for the detector input.
REQ-010 SHALL have port tag, output, 1 bit: registered, high on the first sample of each pulse whose latched width >= 3.
REQ-011 SHALL have port busy, output, 1 bit: high in PULSE and GAP.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a finite train completes.

Function
REQ-013 SHALL implement the states IDLE, PULSE and GAP.
REQ-014 In IDLE with start=1 and stop=0 at edge t, SHALL latch amp/width/period/count, then enter PULSE with q=amp and busy=1 visible after edge t (one-cycle latency).
REQ-015 In PULSE, SHALL drive q=amp for exactly max(width,1) consecutive cycles, then enter GAP.
REQ-016 In GAP, SHALL drive q=baseline for exactly max(period,1) cycles.
REQ-017 At GAP end, SHALL increment an 8-bit pulse counter; if count!=0 and counter==count, SHALL enter IDLE and assert done for exactly that one cycle, else re-enter PULSE.
REQ-018 When count=0, SHALL let the pulse counter wrap at 255->0 with no effect on behaviour.
REQ-019 SHALL set tag only on the first PULSE cycle of a pulse and only if the latched width >= 3, since pulses of width 1-2 do not qualify as spikes under the 3-sample detection rule.
REQ-020 On stop=1 in PULSE or GAP, SHALL enter IDLE on the next edge with q=0, busy=0, tag=0 and no done.
REQ-021 On start and stop high together in IDLE, SHALL remain in IDLE.
REQ-022 SHALL ignore start while busy, and SHALL NOT change latched parameters when the inputs change mid-train.
REQ-023 SHALL pass negative amp unchanged, with no saturation or clamping.
REQ-024 SHALL drive q=baseline in IDLE.

Reset
REQ-025 When rst=1 at an edge, SHALL enter IDLE and set q=0, tag=0, busy=0, done=0, and clear the pulse counter and latched parameters.
REQ-026 SHALL give rst priority over start and stop, including when rst arrives mid-pulse or mid-gap.
REQ-027 SHALL treat the first clock after rst deassertion like any other IDLE cycle, so start is honoured on it.

Configuration
REQ-028 With SPIKE_GEN_NOISE_EN defined, SHALL generate baseline from a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset, advancing every cycle) as a sign-extended 3-bit value in -4..+3 on GAP and IDLE samples only.
REQ-029 With SPIKE_GEN_NOISE_EN defined, PULSE samples SHALL remain exactly amp.
REQ-030 Without SPIKE_GEN_NOISE_EN, SHALL make baseline constant 0 and SHALL NOT instantiate the LFSR.

Verification
REQ-031 Bench SHALL cover: rst, then start with amp=100, width=3, period=4, count=2 -> q=100 for 3 cycles, then 0 for 4, then 100 for 3, then 0 for 4; tag high on cycles 1 and 8; done on cycle 14; busy 14 cycles.
REQ-032 Bench SHALL cover: width=2, amp=50, count=1, period=2 -> q=50 for 2 cycles, tag never high, done after cycle 4.
REQ-033 Bench SHALL cover: width=0, period=0, count=3 -> pulses alternate 1 sample amp, 1 sample baseline, 6 busy cycles, done once.
REQ-034 Bench SHALL cover: count=0 with stop on cycle 600 -> continuous train across counter wrap, then q=0 and busy=0 one cycle after stop, no done.
REQ-035 Bench SHALL cover: rst asserted during the second PULSE cycle -> all outputs 0 after that edge, and a start issued next cycle restarts cleanly.
REQ-036 Bench SHALL cover, with SPIKE_GEN_NOISE_EN defined, amp=-200: every baseline sample within -4..+3, every pulse sample exactly -200, and an identical q sequence after each reset.
